// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, default
// geometry and address field extraction helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Default geometry; the top module re-derives widths from its own parameters.
  localparam int DEF_NUM_LINES      = 64;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int OFF_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX_W = $clog2(DEF_NUM_LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;

  // Word-within-line field, right-aligned.
  function automatic logic [31:0] addr_word(input logic [31:0] addr,
                                            input int off_w = OFF_W);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  // Line index field, right-aligned.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int off_w = OFF_W,
                                             input int idx_w = IDX_W);
    return (addr >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag field, right-aligned.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int off_w = OFF_W,
                                           input int idx_w = IDX_W);
    return addr >> (off_w + idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Storage for the instruction cache: data words (sync write, async read),
// per-line tags and valid bits with a single-cycle clear-all.
module icache_line_store #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 6,
  parameter int OFF_W          = 2,
  parameter int TAG_W          = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_word,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             clear_all
);

  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // Refill beats land in the data array one word at a time.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_word}] <= wr_data;
  end

  // Tag is written together with the final beat of a line.
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[fill_idx] <= fill_tag;
  end

  // Valid bits: clear-all wins over a same-cycle fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  assign rd_data  = data_mem[{rd_idx, rd_word}];
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped read-only instruction cache: combinational hit path and a
// linear, one-word-per-beat line refill over the memory req/ready port.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int LINE_OFF_W = $clog2(WORDS_PER_LINE);
  localparam int LINE_IDX_W = $clog2(NUM_LINES);
  localparam int LINE_TAG_W = 32 - LINE_OFF_W - LINE_IDX_W - 2;
  localparam logic [LINE_OFF_W-1:0] LAST_BEAT = LINE_OFF_W'(WORDS_PER_LINE - 1);

  // Memory handshake: mem_req is raised in REQ and held, with mem_addr stable,
  // until a cycle with mem_ready=1; that cycle completes the beat and mem_rdata
  // is captured at its edge. The responder keeps ready high while req is held,
  // so req always drops for one GAP cycle between beats; ready is ignored
  // outside REQ.

  state_e                  state_q;
  logic                    mem_req_q;
  logic [LINE_TAG_W-1:0]   miss_tag_q;
  logic [LINE_IDX_W-1:0]   miss_idx_q;
  logic [LINE_OFF_W-1:0]   beat_q;

  logic [LINE_TAG_W-1:0]   cur_tag;
  logic [LINE_IDX_W-1:0]   cur_idx;
  logic [LINE_OFF_W-1:0]   cur_word;
  logic [31:0]             rd_data;
  logic                    rd_valid;
  logic [LINE_TAG_W-1:0]   rd_tag;
  logic                    idle_req;
  logic                    hit;
  logic                    miss_start;
  logic                    beat_done;
  logic                    line_done;

  assign cur_tag  = LINE_TAG_W'(addr_tag(cpu_addr, LINE_OFF_W, LINE_IDX_W));
  assign cur_idx  = LINE_IDX_W'(addr_index(cpu_addr, LINE_OFF_W, LINE_IDX_W));
  assign cur_word = LINE_OFF_W'(addr_word(cpu_addr, LINE_OFF_W));

  // A flush in IDLE suppresses both the hit and a miss launch.
  assign idle_req   = (state_q == ST_IDLE) && cpu_req && !flush;
  assign hit        = idle_req && rd_valid && (rd_tag == cur_tag);
  assign miss_start = idle_req && !(rd_valid && (rd_tag == cur_tag));
  assign beat_done  = (state_q == ST_REQ) && mem_ready && !flush;
  assign line_done  = beat_done && (beat_q == LAST_BEAT);

  assign cpu_ready = hit;
  assign cpu_rdata = hit ? rd_data : 32'd0;
  assign mem_req   = mem_req_q;
  assign mem_addr  = {miss_tag_q, miss_idx_q, beat_q, 2'b00};

  icache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (LINE_IDX_W),
    .OFF_W          (LINE_OFF_W),
    .TAG_W          (LINE_TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (cur_idx),
    .rd_word   (cur_word),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .wr_en     (beat_done),
    .wr_idx    (miss_idx_q),
    .wr_word   (beat_q),
    .wr_data   (mem_rdata),
    .fill_en   (line_done),
    .fill_idx  (miss_idx_q),
    .fill_tag  (miss_tag_q),
    .clear_all (flush)
  );

  // Refill FSM: latch the missing line, walk its words with a gap between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      beat_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_start) begin
            miss_tag_q <= cur_tag;
            miss_idx_q <= cur_idx;
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_IDLE;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            mem_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: randomized-latency memory responder,
// line-level reference cache model, and queues of expected hit data and
// expected refill beat addresses.
module tb_icache_refill_ctrl;

  localparam int NL         = 64;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = 4 * WPL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic [31:0] mem_addr;

  int checks = 0;
  int passed = 0;
  int beats_done = 0;
  int lat_force = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_beat_q[$];
  bit          model_valid[NL];
  int unsigned model_tag[NL];

  icache_refill_ctrl #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Clock
  always #5 clk = ~clk;

  // Backing memory contents: fixed pseudo-random function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    foreach (model_valid[i]) model_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver: predict miss/hit from the line model, queue expectations, present the fetch.
  task automatic fetch(input logic [31:0] a);
    int unsigned idx;
    int unsigned tag;
    logic [31:0] base;
    bit got;
    idx  = (a / LINE_BYTES) % NL;
    tag  = a / (LINE_BYTES * NL);
    base = a - (a % LINE_BYTES);
    if (!(model_valid[idx] && model_tag[idx] == tag)) begin
      for (int k = 0; k < WPL; k++) exp_beat_q.push_back(base + 32'(4 * k));
      model_valid[idx] = 1'b1;
      model_tag[idx]   = tag;
    end
    exp_q.push_back(mem_word(a & ~32'd3));
    cpu_req  = 1'b1;
    cpu_addr = a;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cpu_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (got) passed++;
    else $display("FAIL fetch_timeout: addr %h got no cpu_ready in 400 cycles, expected a hit", a);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  // Monitor: every hit pops one expected word; no stray data when not ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_hit: got cpu_ready with data %h, expected no response", cpu_rdata);
        end else begin
          check("hit_data", cpu_rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_not_ready", cpu_rdata, 32'd0);
      end
    end
  end

  // Memory responder: ready after 1, 3 or 7 cycles of held req; checks beat order and gaps.
  initial begin
    logic [31:0] a0;
    int lat;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        a0 = mem_addr;
        if (lat_force != 0) lat = lat_force;
        else begin
          case ($urandom_range(0, 2))
            0:       lat = 1;
            1:       lat = 3;
            default: lat = 7;
          endcase
        end
        aborted = 1'b0;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n || !mem_req) begin
            aborted = 1'b1;
            break;
          end
          check("mem_addr_stable", mem_addr, a0);
        end
        if (!aborted) begin
          if (exp_beat_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got mem_req at %h, expected no refill", a0);
          end else begin
            check("beat_addr", a0, exp_beat_q.pop_front());
          end
          mem_ready = 1'b1;
          mem_rdata = mem_word(a0);
          beats_done++;
          @(negedge clk);
          mem_ready = 1'b0;
          mem_rdata = $urandom();
          check("gap_after_beat", 32'(mem_req), 32'd0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int b0;
    bit seen;
    logic [31:0] a;

    // Reset state, with a fetch already pending.
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0104;
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();

    // Cold miss, then hits on the same line.
    fetch(32'h0000_0104);
    b0 = beats_done;
    fetch(32'h0000_0100);
    fetch(32'h0000_0108);
    fetch(32'h0000_010C);
    check("hits_no_beats", 32'(beats_done - b0), 32'd0);

    // Conflict eviction on index 0.
    fetch(32'h0000_0000);
    fetch(32'h0000_0400);
    fetch(32'h0000_0000);

    // Flush during the second REQ beat.
    lat_force = 7;
    for (int k = 0; k < WPL; k++) exp_beat_q.push_back(32'h2000 + 32'(4 * k));
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_2000;
    b0 = beats_done;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (beats_done != b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("flush_first_beat_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    cpu_req = 1'b0;
    check("flush_abort_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("flush_idle_req", 32'(mem_req), 32'd0);
    check("flush_beats_left", 32'(exp_beat_q.size()), 32'(WPL - 1));
    exp_beat_q.delete();
    model_clear();
    lat_force = 0;
    idle(1);
    fetch(32'h0000_2000);
    fetch(32'h0000_0104);

    // Flush in IDLE suppresses a hit and a miss launch.
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0104;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_hit_suppressed", 32'(cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    cpu_addr = 32'h0000_5000;
    model_clear();
    @(posedge clk);
    #1;
    flush   = 1'b0;
    cpu_req = 1'b0;
    check("flush_miss_suppressed", 32'(mem_req), 32'd0);
    fetch(32'h0000_0104);

    // Random fetches over a small conflicting address set, occasional flushes.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_clear();
      end
      a = 32'($urandom_range(0, 3) * (LINE_BYTES * NL)) + 32'($urandom_range(0, 7) * LINE_BYTES)
        + 32'($urandom_range(0, WPL - 1) * 4) + 32'($urandom_range(0, 3));
      fetch(a);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Asynchronous reset during a GAP cycle.
    exp_beat_q.push_back(32'h0000_3000);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_3004;
    b0 = beats_done;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (beats_done != b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_gap_beat_seen", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gap_mem_req", 32'(mem_req), 32'd0);
    check("rst_gap_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_gap_mem_addr", mem_addr, 32'd0);
    cpu_req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    model_clear();
    fetch(32'h0000_3004);

    // Drain and final bookkeeping.
    idle(20);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("beat_q_drained", 32'(exp_beat_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped, read-only instruction cache. Sits between the fetch stage and the instruction port of the memory subsystem.
- Acts as initiator on the word-wide req/ready memory interface and refills whole lines one word per beat.
- Serves fetch hits combinationally in the same cycle. Supports a full invalidate (fence.i).

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2, minimum 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, minimum 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cpu_req  input  1  fetch request
- cpu_addr  input  32  fetch byte address; bits [1:0] ignored
- cpu_rdata  output  32  instruction word; valid when cpu_ready=1
- cpu_ready  output  1  hit response, same cycle as the request
- flush  input  1  invalidate all lines (one-cycle pulse)
- mem_req  output  1  memory request
- mem_addr  output  32  word-aligned refill address
- mem_rdata  input  32  memory read data
- mem_ready  input  1  beat complete; mem_rdata valid this cycle

Behaviour:
- Address split: OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(NUM_LINES).
  - word = addr[OFF_W+1:2]
  - index = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = addr[31:OFF_W+IDX_W+2]
- Reset values: all valid bits 0, state IDLE, mem_req 0, mem_addr 0, beat counter 0, cpu_ready 0, cpu_rdata 0.
- Hit condition: state==IDLE && cpu_req && valid[index] && tag_store[index]==tag.
  - On hit: cpu_ready=1 and cpu_rdata=data[index][word], combinationally.
  - Otherwise cpu_ready=0. cpu_rdata is don't-care and is driven 0 when not ready.
- States: IDLE, REQ, GAP.
  - IDLE: on cpu_req miss with flush=0, latch miss tag/index, clear beat counter, go to REQ.
  - REQ: mem_req=1, mem_addr={miss_tag, miss_index, beat, 2'b00}, held stable.
    - On a cycle with mem_ready=1: write mem_rdata into data[miss_index][beat] at that edge.
    - If beat==WORDS_PER_LINE-1: set valid[miss_index]=1, tag_store[miss_index]=miss_tag, go to IDLE.
    - Otherwise: beat+1, go to GAP.
  - GAP: mem_req=0 for exactly one cycle; mem_ready is ignored; go to REQ.
    - The gap is mandatory: the responder holds ready high while req is held, so dropping req is the only safe beat separator.
- mem_ready is sampled only in REQ. Any latency of 1 or more cycles is tolerated.
- mem_req is registered, with no combinational path from cpu_* to mem_*.
- Refill order is linear from word 0. No critical-word-first. The request replays as a hit in IDLE after the refill completes (minimum one extra cycle).
- cpu_addr may change during a refill. The latched line still completes, then lookup uses the current cpu_addr.
- cpu_req dropping during a refill does not abort it.
- flush:
  - In any state, clears all valid bits at the edge.
  - In REQ or GAP, aborts the refill: next state IDLE, mem_req=0, partial line not validated.
  - In IDLE, suppresses a same-cycle hit (cpu_ready=0) and a miss launch.
- Asynchronous reset mid-refill returns all state to reset values immediately. The partial line is discarded.
- Beat counter is OFF_W bits wide and wraps to 0 only on refill start.

Decomposition:
- Package icache_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, GAP=2'd2)
  - localparam helpers OFF_W, IDX_W, TAG_W, and tag/index/word field-extract functions.
- One sub-module, icache_line_store:
  - data array NUM_LINES*WORDS_PER_LINE x 32 with one synchronous write port and one asynchronous read port;
  - tag array plus valid bits with a single-cycle clear-all.
- The FSM, counter and hit logic live in the top module.

Test Plan:
- Cold miss: reset, cpu_req=1, cpu_addr=0x0000_0104.
  - Expected: mem_req beats at 0x100, 0x104, 0x108, 0x10C, each separated by one mem_req=0 cycle.
  - After the last beat: cpu_ready=1 with cpu_rdata equal to the memory word at 0x104.
- Hit after refill: fetch 0x100, 0x108, 0x10C back-to-back.
  - Expected: cpu_ready=1 each cycle, correct words, mem_req stays 0.
- Conflict eviction (defaults): load 0x0000_0000, then fetch 0x0000_0400 (same index 0, different tag).
  - Expected: refill at 0x400..0x40C.
  - Re-fetch of 0x000 misses again.
- Flush mid-refill: assert flush during the second REQ beat.
  - Expected: mem_req=0 next cycle, state IDLE.
  - Re-fetch of the same address restarts from beat 0 at the line base; a previously cached line also misses.
- Variable memory latency: the memory model returns ready after 1, 3 and 7 cycles randomly.
  - Expected: every beat accepted exactly once, mem_addr stable while in REQ, data correct for 500 random fetches against a reference model.
- Async reset asserted mid-GAP:
  - Expected: mem_req=0 immediately, cpu_ready=0.
  - After release, a fetch to the same line performs a full refill.
